// File: rtl/cmp_event_monitor.sv
// cmp_event_monitor: consumes the magnitude comparator's result flags. It keeps
// saturating per-outcome counters, tracks the current run of identical outcomes,
// and raises an alarm that stays set until ack when a run reaches STREAK_TH.
// Optional: define CMP_ONEHOT_CHECK_EN to add a sticky 'illegal' output that
// flags non-one-hot samples.
module cmp_event_monitor #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned STREAK_TH = 4,
    parameter int unsigned STK_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a_grater,
    input  logic             a_equal,
    input  logic             a_lesser,
    input  logic             clr,
    input  logic             ack,
    output logic [CNT_W-1:0] cnt_grater,
    output logic [CNT_W-1:0] cnt_equal,
    output logic [CNT_W-1:0] cnt_lesser,
    output logic [1:0]       streak_type,
    output logic [STK_W-1:0] streak_len,
`ifdef CMP_ONEHOT_CHECK_EN
    output logic             illegal,
`endif
    output logic             alarm
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_ALARM,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [STK_W-1:0] STK_MAX = '1;
    localparam logic [STK_W-1:0] TH_V    = STK_W'(STREAK_TH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_grater_q, cnt_grater_d;
    logic [CNT_W-1:0] cnt_equal_q, cnt_equal_d;
    logic [CNT_W-1:0] cnt_lesser_q, cnt_lesser_d;
    logic [1:0]       streak_type_q, streak_type_d;
    logic [STK_W-1:0] streak_len_q, streak_len_d;
    logic             alarm_q, alarm_d;

    logic [2:0]       flags;
    logic             onehot;
    logic             accept;
    logic             same_type;
    logic [1:0]       sample_type;

    // Decode the comparator flags into an outcome code and an acceptance strobe
    always_comb begin
        flags       = {a_grater, a_equal, a_lesser};
        onehot      = 1'b0;
        sample_type = 2'b00;
        case (flags)
            3'b100: begin onehot = 1'b1; sample_type = 2'b01; end
            3'b010: begin onehot = 1'b1; sample_type = 2'b10; end
            3'b001: begin onehot = 1'b1; sample_type = 2'b11; end
            default: begin onehot = 1'b0; sample_type = 2'b00; end
        endcase
        accept    = in_valid && onehot;
        same_type = (sample_type == streak_type_q);
    end

    // Next-state logic: counters, streak tracking and alarm FSM; clr dominates
    always_comb begin
        state_d       = state_q;
        cnt_grater_d  = cnt_grater_q;
        cnt_equal_d   = cnt_equal_q;
        cnt_lesser_d  = cnt_lesser_q;
        streak_type_d = streak_type_q;
        streak_len_d  = streak_len_q;

        if (clr) begin
            state_d       = S_IDLE;
            cnt_grater_d  = '0;
            cnt_equal_d   = '0;
            cnt_lesser_d  = '0;
            streak_type_d = 2'b00;
            streak_len_d  = '0;
        end else begin
            if (accept) begin
                case (sample_type)
                    2'b01:   if (cnt_grater_q != CNT_MAX) cnt_grater_d = cnt_grater_q + 1'b1;
                    2'b10:   if (cnt_equal_q  != CNT_MAX) cnt_equal_d  = cnt_equal_q  + 1'b1;
                    default: if (cnt_lesser_q != CNT_MAX) cnt_lesser_d = cnt_lesser_q + 1'b1;
                endcase
                if (same_type) begin
                    if (streak_len_q != STK_MAX) streak_len_d = streak_len_q + 1'b1;
                end else begin
                    streak_type_d = sample_type;
                    streak_len_d  = STK_W'(1);
                end
            end

            case (state_q)
                S_IDLE:  if (accept) state_d = S_TRACK;
                S_TRACK: if (accept && streak_len_d == TH_V) state_d = S_ALARM;
                // A type change arriving together with ack starts a fresh run
                S_ALARM: if (ack) state_d = (accept && !same_type) ? S_TRACK : S_HOLD;
                S_HOLD:  if (accept && !same_type) state_d = S_TRACK;
                default: state_d = S_IDLE;
            endcase
        end

        alarm_d = (state_d == S_ALARM);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_grater_q  <= '0;
            cnt_equal_q   <= '0;
            cnt_lesser_q  <= '0;
            streak_type_q <= 2'b00;
            streak_len_q  <= '0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_grater_q  <= cnt_grater_d;
            cnt_equal_q   <= cnt_equal_d;
            cnt_lesser_q  <= cnt_lesser_d;
            streak_type_q <= streak_type_d;
            streak_len_q  <= streak_len_d;
            alarm_q       <= alarm_d;
        end
    end

    assign cnt_grater  = cnt_grater_q;
    assign cnt_equal   = cnt_equal_q;
    assign cnt_lesser  = cnt_lesser_q;
    assign streak_type = streak_type_q;
    assign streak_len  = streak_len_q;
    assign alarm       = alarm_q;

`ifdef CMP_ONEHOT_CHECK_EN
    logic illegal_q, illegal_d;

    // Sticky flag for any valid non-one-hot sample; only rst/clr clear it
    always_comb begin
        illegal_d = illegal_q;
        if (clr) illegal_d = 1'b0;
        else if (in_valid && !onehot) illegal_d = 1'b1;
    end

    // Illegal-sample flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Self-checking bench for cmp_event_monitor: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_cmp_event_monitor;

    localparam int CNT_W = 8;
    localparam int TH    = 4;
    localparam int STK_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int SMAX  = (1 << STK_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             a_grater = 1'b0;
    logic             a_equal  = 1'b0;
    logic             a_lesser = 1'b0;
    logic             clr = 1'b0;
    logic             ack = 1'b0;
    logic [CNT_W-1:0] cnt_grater, cnt_equal, cnt_lesser;
    logic [1:0]       streak_type;
    logic [STK_W-1:0] streak_len;
    logic             alarm;
`ifdef CMP_ONEHOT_CHECK_EN
    logic             illegal;
`endif

    cmp_event_monitor #(.CNT_W(CNT_W), .STREAK_TH(TH), .STK_W(STK_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a_grater(a_grater), .a_equal(a_equal), .a_lesser(a_lesser),
        .clr(clr), .ack(ack),
        .cnt_grater(cnt_grater), .cnt_equal(cnt_equal), .cnt_lesser(cnt_lesser),
        .streak_type(streak_type), .streak_len(streak_len),
`ifdef CMP_ONEHOT_CHECK_EN
        .illegal(illegal),
`endif
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts per outcome (1=G,2=E,3=L), run state, alarm latch
    int m_cnt[1:3];
    int m_type;
    int m_len;
    bit m_alarm;
    bit m_reported;   // current run already acknowledged; must not re-alarm
    bit m_illegal;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt[1] = 0; m_cnt[2] = 0; m_cnt[3] = 0;
        m_type = 0; m_len = 0;
        m_alarm = 0; m_reported = 0; m_illegal = 0;
    endtask

    task automatic model_update(input bit v, input logic [2:0] f, input bit c, input bit a);
        int  t;
        bit  acc, chg;
        t = (f == 3'b100) ? 1 : (f == 3'b010) ? 2 : (f == 3'b001) ? 3 : 0;
        if (c) begin
            model_reset();
            return;
        end
        acc = v && (t != 0);
        chg = acc && (t != m_type);
        if (v && t == 0) m_illegal = 1;
        if (acc) begin
            if (m_cnt[t] < CMAX) m_cnt[t]++;
            if (chg) begin m_type = t; m_len = 1; end
            else if (m_len < SMAX) m_len++;
        end
        if (m_alarm) begin
            if (a) begin
                m_alarm = 0;
                m_reported = !chg;
            end
        end else if (m_reported) begin
            if (chg) m_reported = 0;
        end else if (acc && m_len == TH) begin
            m_alarm = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cnt_g"}, 32'(cnt_grater), 32'(m_cnt[1]));
        check({tag, ".cnt_e"}, 32'(cnt_equal), 32'(m_cnt[2]));
        check({tag, ".cnt_l"}, 32'(cnt_lesser), 32'(m_cnt[3]));
        check({tag, ".stype"}, 32'(streak_type), 32'(m_type));
        check({tag, ".slen"}, 32'(streak_len), 32'(m_len));
        check({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
`ifdef CMP_ONEHOT_CHECK_EN
        check({tag, ".illegal"}, 32'(illegal), 32'(m_illegal));
`endif
    endtask

    // One clock: drive inputs, advance on the edge, update model, compare #1 later
    task automatic step(input string tag, input bit v, input logic [2:0] f,
                        input bit c, input bit a);
        in_valid = v;
        {a_grater, a_equal, a_lesser} = f;
        clr = c;
        ack = a;
        @(posedge clk);
        model_update(v, f, c, a);
        #1;
        check_all(tag);
    endtask

    task automatic idle_cycle(input string tag);
        step(tag, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] L = 3'b001;

    initial begin
        logic [2:0] f;
        int prev_t;
        int r;

        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) idle_cycle("idle");

        // G,G,E,L,L
        step("seq", 1, G, 0, 0);
        step("seq", 1, G, 0, 0);
        step("seq", 1, E, 0, 0);
        step("seq", 1, L, 0, 0);
        step("seq", 1, L, 0, 0);
        check("seq.cnt_g_const", 32'(cnt_grater), 2);
        check("seq.slen_const", 32'(streak_len), 2);
        check("seq.stype_const", 32'(streak_type), 3);

        // Alarm on 4th E
        for (int i = 0; i < 3; i++) step("erun", 1, E, 0, 0);
        check("erun.no_alarm_yet", 32'(alarm), 0);
        step("erun", 1, E, 0, 0);
        check("erun.alarm_const", 32'(alarm), 1);
        idle_cycle("alarm_hold");

        // ack, then more E: no re-alarm
        step("ack", 0, 3'b000, 0, 1);
        check("ack.alarm_const", 32'(alarm), 0);
        for (int i = 0; i < 3; i++) step("hold_e", 1, E, 0, 0);
        check("hold_e.slen_const", 32'(streak_len), 7);
        check("hold_e.alarm_const", 32'(alarm), 0);

        // New G run re-alarms
        for (int i = 0; i < 4; i++) step("grun", 1, G, 0, 0);
        check("grun.alarm_const", 32'(alarm), 1);

        // Illegal flags dropped, then clr
        step("illegal", 1, 3'b110, 0, 0);
        step("illegal", 1, 3'b000, 0, 0);
        step("illegal", 1, 3'b111, 0, 0);
        step("clr", 0, 3'b000, 1, 0);
        check("clr.cnt_g_const", 32'(cnt_grater), 0);

        // Saturation
        for (int i = 0; i < 300; i++) step("sat", 1, L, 0, (i == 10));
        check("sat.cnt_l_const", 32'(cnt_lesser), 255);
        check("sat.slen_const", 32'(streak_len), 15);
        step("clr2", 0, 3'b000, 1, 0);

        // ack with a type change while in ALARM
        for (int i = 0; i < 4; i++) step("grun2", 1, G, 0, 0);
        step("ack_chg", 1, L, 0, 1);
        check("ack_chg.alarm_const", 32'(alarm), 0);
        check("ack_chg.slen_const", 32'(streak_len), 1);
        // Fresh L run must alarm again (TRACK, not HOLD)
        for (int i = 0; i < 3; i++) step("lrun", 1, L, 0, 0);
        check("lrun.alarm_const", 32'(alarm), 1);

        // Type change in ALARM without ack keeps alarm latched
        step("latched", 1, E, 0, 0);
        check("latched.alarm_const", 32'(alarm), 1);

        // clr beats a valid sample and ack
        step("clr_sample", 1, G, 1, 1);
        check("clr_sample.cnt_g_const", 32'(cnt_grater), 0);

        // Mid-run async reset discards history
        step("pre_rst", 1, E, 0, 0);
        step("pre_rst", 1, E, 0, 0);
        step("pre_rst", 1, E, 0, 0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        #2 rst = 1'b0;
        step("post_rst", 1, E, 0, 0);

        // Randomized traffic
        prev_t = 1;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) f = 3'($urandom_range(0, 7));
            else begin
                if (r > 10) prev_t = int'($urandom_range(1, 3));
                f = (prev_t == 1) ? G : (prev_t == 2) ? E : L;
            end
            step("rand", ($urandom_range(0, 3) != 0), f,
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmp_event_monitor.md
Name: cmp_event_monitor

Overview:
- Downstream consumer of the 4-bit magnitude comparator's three result flags (a_grater, a_equal, a_lesser).
- Samples one comparator result per valid cycle and keeps saturating per-outcome counters.
- Tracks the current run of identical outcomes and raises a latched alarm when a run reaches a threshold.
- Sits between the comparator and the control/status logic that reads counts and acknowledges alarms.

Parameters:
- CNT_W, 8, width of each outcome counter; counters saturate at 2^CNT_W-1.
- STREAK_TH, 4, run length that raises alarm; legal range 2..2^STK_W-1.
- STK_W, 4, width of streak_len; streak_len saturates at 2^STK_W-1.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  comparator flags valid this cycle
- a_grater  input  1  comparator flag: a > b
- a_equal  input  1  comparator flag: a == b
- a_lesser  input  1  comparator flag: a < b
- clr  input  1  synchronous clear of all state
- ack  input  1  alarm acknowledge
- cnt_grater  output  CNT_W  count of accepted grater samples
- cnt_equal  output  CNT_W  count of accepted equal samples
- cnt_lesser  output  CNT_W  count of accepted lesser samples
- streak_type  output  2  00 none, 01 grater, 10 equal, 11 lesser
- streak_len  output  STK_W  length of current run
- alarm  output  1  run reached STREAK_TH, held until ack

Behaviour:
- Reset (async, rst=1): all counters 0, streak_type 00, streak_len 0, alarm 0, FSM IDLE. All outputs are registered.
- Accepted sample: in_valid=1, clr=0, and exactly one of the three flags is high. Any other flag combination is dropped: no counter or streak change.
- Latency: an accepted sample at edge N is visible on the outputs after edge N (one-cycle latency).
- Counters: the matching counter increments by 1 and holds at all-ones (no wrap).
- Streak update:
  - If the sample type equals streak_type, streak_len increments, saturating at 2^STK_W-1.
  - Otherwise streak_type takes the new type and streak_len becomes 1.
- clr: synchronous. It has priority over in_valid and ack. It zeroes counters and streak and forces IDLE with alarm 0.
- FSM states:
  - IDLE: no accepted sample since reset/clr. Any accepted sample goes to TRACK.
  - TRACK: goes to ALARM on the accepted sample that makes the new streak_len equal STREAK_TH. alarm=1 from the next cycle.
  - ALARM: alarm=1. Further same-type samples keep counting. ack goes to HOLD with alarm=0 next cycle. A type change while in ALARM does not clear alarm (latched).
  - HOLD: run already reported. Same-type samples do not re-alarm. The first accepted sample of a different type goes to TRACK with streak_len=1.
- ack in any state other than ALARM: ignored.
- ack and an accepted sample in the same cycle while in ALARM:
  - Both take effect.
  - If the sample changes type, go to TRACK instead of HOLD.
- Reset or clr mid-run discards the run; no alarm is generated from pre-clear history.

Optional Feature:
- Macro: CMP_ONEHOT_CHECK_EN.
- When defined:
  - Adds output port illegal (1 bit).
  - illegal is sticky: it sets one cycle after any in_valid cycle (with clr=0) whose flags are not exactly one-hot.
  - It clears only on rst or clr. The illegal sample is still dropped.
- When undefined: no illegal port, no checker logic; illegal samples are silently dropped.

Test Plan:
- Reset then idle: rst pulse, in_valid=0 for 5 cycles -> all counts 0, streak_type 00, alarm 0.
- Samples G,G,E,L,L (one per cycle, in_valid=1) -> cnt_grater=2, cnt_equal=1, cnt_lesser=2, streak_type=11, streak_len=2, alarm 0.
- Alarm path, STREAK_TH=4:
  - 4 consecutive E -> alarm=1 the cycle after the 4th sample.
  - ack -> alarm=0; 3 more E -> no alarm, streak_len=7.
  - 1 G then 4 G total -> alarm=1 again.
- Saturation, CNT_W=8: 300 consecutive L samples -> cnt_lesser=255, streak_len=15.
- Illegal and clr:
  - Flags 110 with in_valid=1 -> counters unchanged; with CMP_ONEHOT_CHECK_EN, illegal=1.
  - Then clr -> illegal=0 and all counts 0.
- Simultaneous events: in ALARM (grater run), assert ack with an L sample in the same cycle -> alarm=0, state TRACK, streak_type=11, streak_len=1. Separately, clr with in_valid=1 -> the sample is not counted.
